// File: rtl/tile_pkg.sv
// Shared types and default geometry for the minesweeper tile renderer.
// Tile codes follow the game's cell encoding; codes 13-15 have no tile and show background.
package tile_pkg;

  localparam int DEF_GRID_COLS    = 25;
  localparam int DEF_GRID_ROWS    = 18;
  localparam int DEF_TILE_LOG2    = 5;
  localparam int DEF_H_ACTIVE     = 800;
  localparam int DEF_V_ACTIVE     = 600;
  localparam int DEF_BLINK_FRAMES = 16;

  // Colour packed as {B,G,R} nibbles.
  typedef logic [11:0] rgb12_t;

  typedef enum logic [3:0] {
    TILE_HIDDEN   = 4'd0,
    TILE_FLAG     = 4'd1,
    TILE_N1       = 4'd2,
    TILE_N2       = 4'd3,
    TILE_N3       = 4'd4,
    TILE_N4       = 4'd5,
    TILE_N5       = 4'd6,
    TILE_N6       = 4'd7,
    TILE_N7       = 4'd8,
    TILE_N8       = 4'd9,
    TILE_MINE     = 4'd10,
    TILE_EXPLODED = 4'd11,
    TILE_EMPTY    = 4'd12
  } tile_code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } wr_state_e;

endpackage

// File: rtl/minesweeper_tile_renderer_if.sv
// Cell write port between game logic (master) and the tile renderer (slave).
interface minesweeper_tile_renderer_if;
  logic       cell_we;
  logic [4:0] cell_col;
  logic [4:0] cell_row;
  logic [3:0] cell_code;
  logic       clear_req;
  logic       cell_ready;

  modport master (output cell_we, cell_col, cell_row, cell_code, clear_req,
                  input  cell_ready);
  modport slave  (input  cell_we, cell_col, cell_row, cell_code, clear_req,
                  output cell_ready);
endinterface

// File: rtl/tile_map_ram.sv
// Simple dual-port 4-bit cell map: one write port, one synchronous read port.
// A read of an address written in the same cycle returns the previous contents.
module tile_map_ram #(
  parameter int DEPTH  = 450,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_data
);

  logic [3:0] mem [DEPTH];
  logic [3:0] rd_data_d, rd_data_q;

  // NOTE: the array itself is never reset so it maps onto block/distributed RAM.
  always_ff @(posedge pixel_clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_comb rd_data_d = mem[rd_addr];

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/minesweeper_tile_renderer.sv
// Two-stage pixel pipeline: cell-map lookup, then cursor/transparency colour select.
// Also owns the map-clear FSM and the cursor blink counter.
module minesweeper_tile_renderer
  import tile_pkg::*;
#(
  parameter int     GRID_COLS    = DEF_GRID_COLS,
  parameter int     GRID_ROWS    = DEF_GRID_ROWS,
  parameter int     TILE_LOG2    = DEF_TILE_LOG2,
  parameter int     H_ACTIVE     = DEF_H_ACTIVE,
  parameter int     V_ACTIVE     = DEF_V_ACTIVE,
  parameter int     CLEAR_CODE   = 0,
  parameter int     BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter rgb12_t CURSOR_RGB   = 12'hF00
) (
  input  logic                       pixel_clk,
  input  logic                       rst_n,
  input  logic [10:0]                h_coord,
  input  logic [9:0]                 v_coord,
  minesweeper_tile_renderer_if.slave cell_if,
  input  logic                       cursor_en,
  input  logic [4:0]                 cursor_col,
  input  logic [4:0]                 cursor_row,
  output logic [3:0]                 tile_code,
  output logic [2*TILE_LOG2-1:0]     tile_addr,
  input  rgb12_t                     tile_rgb,
  input  rgb12_t                     bg_rgb,
  output logic [3:0]                 red,
  output logic [3:0]                 green,
  output logic [3:0]                 blue
);

  localparam int N      = GRID_COLS * GRID_ROWS;
  localparam int ADDR_W = $clog2(N);
  localparam int TILE   = 1 << TILE_LOG2;
  localparam int CNT_W  = $clog2(BLINK_FRAMES + 1);

  wr_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     clr_addr_q, clr_addr_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic [2*TILE_LOG2-1:0] tile_addr_q, tile_addr_d;
  logic                  in_grid_q, in_grid_d;
  logic                  cursor_hit_q, cursor_hit_d;
  rgb12_t                rgb_q, rgb_d;

  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_waddr, ram_raddr;
  logic [3:0]            ram_wdata, ram_rdata;
  logic                  wr_in_grid, eof, on_border;
  logic [10:0]           pix_col;
  logic [9:0]            pix_row;
  logic [TILE_LOG2-1:0]  px, py;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    ram_wdata  = cell_if.cell_code;
    wr_in_grid = (cell_if.cell_col < 5'(GRID_COLS)) && (cell_if.cell_row < 5'(GRID_ROWS));
    case (state_q)
      ST_IDLE: begin
        // A clear in the same cycle as a write wins; the write is dropped.
        if (cell_if.clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (cell_if.cell_we && wr_in_grid) begin
          ram_we    = 1'b1;
          ram_waddr = ADDR_W'(cell_if.cell_row) * ADDR_W'(GRID_COLS) + ADDR_W'(cell_if.cell_col);
        end
      end
      ST_CLEAR: begin
        ram_we     = 1'b1;
        ram_waddr  = clr_addr_q;
        ram_wdata  = 4'(CLEAR_CODE);
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_W'(N - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cell_if.cell_ready = (state_q == ST_IDLE);

  always_comb begin
    eof         = (h_coord == 11'(H_ACTIVE - 1)) && (v_coord == 10'(V_ACTIVE - 1));
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (eof) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: locate the cell, issue the map read, register texel address and flags.
  always_comb begin
    pix_col   = h_coord >> TILE_LOG2;
    pix_row   = v_coord >> TILE_LOG2;
    px        = h_coord[TILE_LOG2-1:0];
    py        = v_coord[TILE_LOG2-1:0];
    in_grid_d = (h_coord < 11'(H_ACTIVE)) && (v_coord < 10'(V_ACTIVE)) &&
                (pix_col < 11'(GRID_COLS)) && (pix_row < 10'(GRID_ROWS));
    ram_raddr = in_grid_d ? (ADDR_W'(pix_row) * ADDR_W'(GRID_COLS) + ADDR_W'(pix_col)) : '0;
    on_border = (px < TILE_LOG2'(2)) || (px >= TILE_LOG2'(TILE - 2)) ||
                (py < TILE_LOG2'(2)) || (py >= TILE_LOG2'(TILE - 2));
    cursor_hit_d = cursor_en && in_grid_d && on_border && blink_on_q &&
                   (pix_col == 11'(cursor_col)) && (pix_row == 10'(cursor_row));
    tile_addr_d  = {py, px};
  end

  // Stage 2: texel 12'h000 is transparent.
  always_comb begin
    rgb_d = tile_rgb;
    if (!in_grid_q)             rgb_d = bg_rgb;
    else if (cursor_hit_q)      rgb_d = CURSOR_RGB;
    else if (tile_rgb == '0)    rgb_d = bg_rgb;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_addr_q   <= '0;
      frame_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      tile_addr_q  <= '0;
      in_grid_q    <= 1'b0;
      cursor_hit_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_on_q   <= blink_on_d;
      tile_addr_q  <= tile_addr_d;
      in_grid_q    <= in_grid_d;
      cursor_hit_q <= cursor_hit_d;
      rgb_q        <= rgb_d;
    end
  end

  tile_map_ram #(.DEPTH(N), .ADDR_W(ADDR_W)) u_map (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .we        (ram_we),
    .wr_addr   (ram_waddr),
    .wr_data   (ram_wdata),
    .rd_addr   (ram_raddr),
    .rd_data   (ram_rdata)
  );

  assign tile_code = ram_rdata;
  assign tile_addr = tile_addr_q;
  assign red       = rgb_q[3:0];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[11:8];

endmodule

// File: tb/tb_minesweeper_tile_renderer.sv
// Directed bench for minesweeper_tile_renderer: vector table for the pixel path,
// hand sequences for clear, collision, reset-abort and cursor blink.
module tb_minesweeper_tile_renderer;

  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic        cursor_en;
  logic [4:0]  cursor_col, cursor_row;
  logic [3:0]  tile_code;
  logic [9:0]  tile_addr;
  logic [11:0] tile_rgb, bg_rgb;
  logic [3:0]  red, green, blue;

  int n_cmp = 0;
  int n_err = 0;

  minesweeper_tile_renderer_if cell_if ();

  minesweeper_tile_renderer dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .h_coord    (h_coord),
    .v_coord    (v_coord),
    .cell_if    (cell_if),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .tile_code  (tile_code),
    .tile_addr  (tile_addr),
    .tile_rgb   (tile_rgb),
    .bg_rgb     (bg_rgb),
    .red        (red),
    .green      (green),
    .blue       (blue)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        cur_en;
    logic [4:0]  cur_col;
    logic [4:0]  cur_row;
    logic [11:0] texel;
    logic [11:0] bg;
    logic        chk_code;
    logic [3:0]  exp_code;
    logic [9:0]  exp_addr;
    logic [11:0] exp_rgb;
  } vec_t;

  function automatic vec_t mk(input logic [10:0] h, input logic [9:0] v, input logic en,
                              input logic [4:0] cc, input logic [4:0] cr,
                              input logic [11:0] tex, input logic [11:0] bg,
                              input logic chk, input logic [3:0] code,
                              input logic [9:0] addr, input logic [11:0] rgb);
    vec_t r;
    r.h = h; r.v = v; r.cur_en = en; r.cur_col = cc; r.cur_row = cr;
    r.texel = tex; r.bg = bg; r.chk_code = chk; r.exp_code = code;
    r.exp_addr = addr; r.exp_rgb = rgb;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic render(input vec_t vv, output logic [3:0] code,
                        output logic [9:0] addr, output logic [11:0] rgb);
    h_coord    = vv.h;
    v_coord    = vv.v;
    cursor_en  = vv.cur_en;
    cursor_col = vv.cur_col;
    cursor_row = vv.cur_row;
    step();
    code     = tile_code;
    addr     = tile_addr;
    tile_rgb = vv.texel;
    bg_rgb   = vv.bg;
    step();
    rgb = {blue, green, red};
  endtask

  task automatic write_cell(input logic [4:0] col, input logic [4:0] row, input logic [3:0] code);
    cell_if.cell_we   = 1'b1;
    cell_if.cell_col  = col;
    cell_if.cell_row  = row;
    cell_if.cell_code = code;
    step();
    cell_if.cell_we   = 1'b0;
  endtask

  task automatic read_cell(input int col, input int row, output logic [3:0] code);
    h_coord = 11'(col * 32 + 16);
    v_coord = 10'(row * 32 + 16);
    step();
    code = tile_code;
  endtask

  task automatic frames(input int n);
    h_coord = 11'd799;
    v_coord = 10'd599;
    repeat (n) step();
  endtask

  vec_t        vecs [19];
  vec_t        bv;
  logic [3:0]  code;
  logic [9:0]  addr;
  logic [11:0] rgb;
  int          cnt, bad;

  initial begin
    h_coord = '0; v_coord = '0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    tile_rgb = '0; bg_rgb = '0;
    cell_if.cell_we = 1'b0; cell_if.cell_col = '0; cell_if.cell_row = '0;
    cell_if.cell_code = '0; cell_if.clear_req = 1'b0;

    // Reset state.
    repeat (3) step();
    check("reset_ready", cell_if.cell_ready, 1);
    check("reset_code", tile_code, 0);
    check("reset_addr", tile_addr, 0);
    check("reset_rgb", {blue, green, red}, 0);
    rst_n = 1'b1;
    step();

    // Full clear; a write and a second clear_req during it must be ignored.
    cell_if.clear_req = 1'b1;
    step();
    cell_if.clear_req = 1'b0;
    check("clear_ready_low", cell_if.cell_ready, 0);
    cnt = 0;
    while (cell_if.cell_ready !== 1'b1 && cnt < 1000) begin
      cnt++;
      cell_if.cell_we   = (cnt == 100);
      cell_if.cell_col  = 5'd3;
      cell_if.cell_row  = 5'd2;
      cell_if.cell_code = 4'd7;
      cell_if.clear_req = (cnt == 200);
      step();
    end
    cell_if.cell_we = 1'b0;
    cell_if.clear_req = 1'b0;
    check("clear_length", cnt, 450);

    bad = 0;
    for (int r = 0; r < 18; r++)
      for (int c = 0; c < 25; c++) begin
        read_cell(c, r, code);
        if (code !== 4'd0) bad++;
      end
    check("clear_nonzero_cells", bad, 0);

    // Out-of-range column write dropped (would alias onto cell (0,1)).
    write_cell(5'd25, 5'd0, 4'd5);
    read_cell(0, 1, code);
    check("oob_write_dropped", code, 0);

    write_cell(5'd3, 5'd2, 4'd1);

    vecs[0]  = mk(101, 71,  0, 0, 0,  12'h5A3, 12'h888, 1, 1, 229,  12'h5A3);
    vecs[1]  = mk(0,   0,   0, 0, 0,  12'h123, 12'h888, 1, 0, 0,    12'h123);
    vecs[2]  = mk(799, 575, 0, 0, 0,  12'h0F0, 12'h888, 1, 0, 1023, 12'h0F0);
    vecs[3]  = mk(800, 10,  0, 0, 0,  12'h0F0, 12'h888, 0, 0, 320,  12'h888);
    vecs[4]  = mk(100, 580, 0, 0, 0,  12'h0F0, 12'h888, 0, 0, 132,  12'h888);
    vecs[5]  = mk(101, 71,  0, 0, 0,  12'h000, 12'h3C7, 1, 1, 229,  12'h3C7);
    vecs[6]  = mk(96,  64,  0, 0, 0,  12'h777, 12'h888, 1, 1, 0,    12'h777);
    vecs[7]  = mk(95,  64,  0, 0, 0,  12'h777, 12'h888, 1, 0, 31,   12'h777);
    vecs[8]  = mk(1,   10,  1, 0, 0,  12'h0F0, 12'h888, 1, 0, 321,  12'hF00);
    vecs[9]  = mk(10,  10,  1, 0, 0,  12'h0F0, 12'h888, 1, 0, 330,  12'h0F0);
    vecs[10] = mk(31,  31,  1, 0, 0,  12'h0F0, 12'h888, 1, 0, 1023, 12'hF00);
    vecs[11] = mk(1,   10,  0, 0, 0,  12'h0F0, 12'h888, 1, 0, 321,  12'h0F0);
    vecs[12] = mk(101, 71,  1, 3, 2,  12'h5A3, 12'h888, 1, 1, 229,  12'h5A3);
    vecs[13] = mk(127, 71,  1, 3, 2,  12'h5A3, 12'h888, 1, 1, 255,  12'hF00);
    vecs[14] = mk(96,  65,  1, 3, 2,  12'h5A3, 12'h888, 1, 1, 32,   12'hF00);
    vecs[15] = mk(33,  1,   1, 0, 0,  12'h0F0, 12'h888, 1, 0, 33,   12'h0F0);
    vecs[16] = mk(1,   10,  1, 0, 0,  12'h000, 12'h888, 1, 0, 321,  12'hF00);
    vecs[17] = mk(799, 575, 1, 24, 17, 12'h0F0, 12'h888, 1, 0, 1023, 12'hF00);
    vecs[18] = mk(801, 1,   1, 25, 0, 12'h0F0, 12'h888, 0, 0, 33,   12'h888);

    for (int i = 0; i < 19; i++) begin
      render(vecs[i], code, addr, rgb);
      if (vecs[i].chk_code) check($sformatf("vec%0d_code", i), code, vecs[i].exp_code);
      check($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_rgb", i), rgb, vecs[i].exp_rgb);
    end
    cursor_en = 1'b0;

    // Same-cycle write and read of cell (5,5): old code first, new code next cycle.
    write_cell(5'd5, 5'd5, 4'd2);
    h_coord = 11'd176;
    v_coord = 10'd176;
    cell_if.cell_we = 1'b1; cell_if.cell_col = 5'd5; cell_if.cell_row = 5'd5; cell_if.cell_code = 4'd4;
    step();
    cell_if.cell_we = 1'b0;
    check("collision_old", tile_code, 2);
    step();
    check("collision_new", tile_code, 4);

    // Clear wins over a simultaneous write; reset mid-clear aborts with the map partially written.
    write_cell(5'd0, 5'd0, 4'd12);
    cell_if.clear_req = 1'b1;
    cell_if.cell_we = 1'b1; cell_if.cell_col = 5'd5; cell_if.cell_row = 5'd5; cell_if.cell_code = 4'd9;
    step();
    cell_if.clear_req = 1'b0;
    cell_if.cell_we = 1'b0;
    check("clear2_started", cell_if.cell_ready, 0);
    repeat (50) step();
    check("clear2_still_busy", cell_if.cell_ready, 0);
    rst_n = 1'b0;
    step();
    check("reset_abort_ready", cell_if.cell_ready, 1);
    rst_n = 1'b1;
    read_cell(5, 5, code);
    check("dropped_write_cell55", code, 4);
    read_cell(0, 0, code);
    check("partial_clear_cell00", code, 0);
    check("idle_after_abort", cell_if.cell_ready, 1);

    // Cursor blink: phase flips every 16 end-of-frame events.
    bv = mk(1, 10, 1, 0, 0, 12'h0F0, 12'h888, 1, 0, 321, 12'hF00);
    frames(15);
    render(bv, code, addr, rgb);
    check("blink_15_on", rgb, 12'hF00);
    frames(1);
    render(bv, code, addr, rgb);
    check("blink_16_off", rgb, 12'h0F0);
    frames(15);
    render(bv, code, addr, rgb);
    check("blink_31_off", rgb, 12'h0F0);
    frames(1);
    render(bv, code, addr, rgb);
    check("blink_32_on", rgb, 12'hF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/minesweeper_tile_renderer.md
# minesweeper_tile_renderer

Pixel-pipelined tile-map renderer for the 800x600 SVGA game path. It holds a cell-code map of GRID_COLS x GRID_ROWS cells and converts each pixel coordinate into a tile-ROM lookup. It drives the registered RGB outputs with a fixed latency, blended with a blinking cursor border and the switch background. It sits between the SVGA timing generator, which supplies h_coord/v_coord, and the VGA output. Game logic updates cells through a write port, and the external tile-ROM bank returns texels.

## Interface
Parameters:
- GRID_COLS, 25: cells per row.
- GRID_ROWS, 18: cell rows.
- TILE_LOG2, 5: log2 of the tile edge in pixels (32x32 tiles).
- H_ACTIVE, 800: active width.
- V_ACTIVE, 600: active height.
- CLEAR_CODE, 0: code written by a map clear.
- BLINK_FRAMES, 16: frames per cursor blink half-period.
- CURSOR_RGB, 12'hF00: cursor border colour as {B,G,R} nibbles.

Ports:
- Clocking and reset: reset rst_n, synchronous, active-low; clock pixel_clk.
- h_coord, in, 11: pixel column.
- v_coord, in, 10: pixel row.
- cell_we, in, 1: cell write strobe; accepted only when cell_ready=1.
- cell_col, in, 5: write column.
- cell_row, in, 5: write row.
- cell_code, in, 4: tile code to write.
- clear_req, in, 1: one-cycle pulse that starts a full-map fill with CLEAR_CODE.
- cell_ready, out, 1: high when the write port is idle, i.e. not clearing.
- cursor_en, in, 1: enables the cursor overlay.
- cursor_col, in, 5: cursor cell column.
- cursor_row, in, 5: cursor cell row.
- tile_code, out, 4: tile code, to the ROM-bank select.
- tile_addr, out, 2*TILE_LOG2: texel address, computed as (v%tile)*tile + (h%tile).
- tile_rgb, in, 12: combinational texel from the ROM bank for tile_code/tile_addr.
- bg_rgb, in, 12: background colour.
- red, green, blue, out, 4 each: colour output, bits [3:0], [7:4] and [11:8] of the selected 12-bit value.

## Operation
- Codes: 0 hidden, 1 flag, 2–9 show counts 1–8, 10 mine, 11 exploded mine, 12 empty. Codes 13–15 render bg_rgb.
- Map storage: GRID_COLS*GRID_ROWS x 4-bit RAM, one write port and one read port. The write address is cell_row*GRID_COLS + cell_col.
- Writes with cell_col>=GRID_COLS or cell_row>=GRID_ROWS are dropped.
- FSM states:
  - IDLE: cell_ready=1.
  - CLEAR: cell_ready=0. Entered on clear_req in IDLE. Writes CLEAR_CODE to address 0..N-1, one per cycle, where N=GRID_COLS*GRID_ROWS. Returns to IDLE the cycle after writing N-1.
- Write-port rules:
  - clear_req in CLEAR is ignored.
  - cell_we in CLEAR is ignored and not queued.
  - clear_req and cell_we in the same IDLE cycle: the clear wins and the write is dropped.
- In-grid test: col = h>>TILE_LOG2 and row = v>>TILE_LOG2. A pixel is in-grid when h<H_ACTIVE, v<V_ACTIVE, col<GRID_COLS and row<GRID_ROWS.
- Pixel colour, in priority order:
  - Outside grid: bg_rgb.
  - Cursor border: cursor_en=1, the cell is the cursor cell, the pixel is within 2 px of the cell edge, and the blink phase is on. Colour is CURSOR_RGB.
  - tile_rgb==12'h000 is transparent and shows bg_rgb.
  - Otherwise tile_rgb.
- Blink counter:
  - End of frame is h==H_ACTIVE-1 && v==V_ACTIVE-1.
  - A frame counter counts 0..BLINK_FRAMES-1, then wraps and toggles the blink phase.
  - The phase resets to on.

## Timing
- Pipeline: h/v are presented at cycle t.
  - t+1: tile_code (registered map read) and tile_addr are valid, together with the registered in-grid and cursor flags.
  - t+2: red/green/blue are registered.
  - Fixed latency is 2 cycles, with no stalls.
- Write/read collision: a read of an address written in the same cycle returns the old code. The new code is visible from the next cycle.
- A cell_we accepted at cycle t is visible to a read issued at t+1.
- A clear takes exactly N cycles; cell_ready rises on cycle t+N+1 after a clear_req at t.
- Reset values: cell_ready=1, tile_code=0, tile_addr=0, red/green/blue=0, FSM=IDLE, frame counter=0, blink phase=on.
- Map contents are not reset. Software issues clear_req after reset.
- Reset asserted mid-clear aborts the fill, returns the FSM to IDLE and leaves the map partially written.

## Structure
- Package tile_pkg holds:
  - The tile_code_e enum (the 13 codes above).
  - The default grid and tile constants.
  - The RGB12 typedef.
- Sub-module tile_map_ram: a parameterised 4-bit simple dual-port RAM with synchronous read, old-data-on-collision semantics, and an inferable block or distributed RAM.
- The FSM, the blink counter and the pixel pipeline stay in the top module.

## Test plan
- Reset → outputs zero and cell_ready=1. clear_req → cell_ready low for exactly 450 cycles; all cells then read code 0; a cell_we issued during the clear has no effect.
- Write code 1 at (col 3, row 2). Drive h=101, v=71 → at t+1 tile_code=1 and tile_addr=7*32+5=229; at t+2 RGB equals the tile_rgb driven at t+1.
- Write and read the same cell in the same cycle: code 4 over code 2 → the read returns 2; the next-cycle read returns 4.
- Drive v=580 (row 18 ≥ GRID_ROWS) with bg_rgb=12'h888 → RGB=8,8,8. Drive tile_rgb=12'h000 in-grid → bg_rgb shown.
- Cursor at (0,0) with cursor_en=1: pixel (1,10) is CURSOR_RGB and pixel (10,10) is the tile colour. After 16 end-of-frame events, pixel (1,10) shows the tile colour; after 16 more it shows the cursor again.
- clear_req simultaneous with cell_we at (5,5) → the write is dropped. Assert rst_n low mid-clear → cell_ready=1 and the FSM is IDLE on the next cycle.
